// File: rtl/seq_sram_loader_pkg.sv
// ---------------------------------------------------------------------------
// seq_sram_loader_pkg
//   Shared definitions for the host-side SmithWaterman sequence loader:
//   default geometry (bits per base, bank word width, bank address width),
//   helpers deriving bases-per-word and the length-counter width, the loader
//   FSM state encoding and the list-terminator header value.
// ---------------------------------------------------------------------------
package seq_sram_loader_pkg;

  localparam int DEF_NUC_W  = 2;
  localparam int DEF_WORD_W = 16;
  localparam int DEF_ADDR_W = 8;

  // A zero-length header marks the end of a sequence list.
  localparam logic [DEF_WORD_W-1:0] HDR_TERM = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HDR    = 3'd2,
    ST_TERM_T = 3'd3,
    ST_TERM_Q = 3'd4,
    ST_START  = 3'd5,
    ST_SERVE  = 3'd6
  } state_e;

  function automatic int bases_per_word(input int word_w, input int nuc_w);
    return word_w / nuc_w;
  endfunction

  // Enough bits to count every base that fits in one bank.
  function automatic int len_width(input int word_w, input int nuc_w, input int addr_w);
    return $clog2(word_w / nuc_w) + addr_w;
  endfunction

endpackage

// File: rtl/seq_sram_loader_bank.sv
// ---------------------------------------------------------------------------
// seq_bank
//   One 2^ADDR_W x WORD_W word bank: a synchronous write port and a
//   registered read port. Array contents are never cleared; only the read
//   register resets (so the loader's data output reads 0 in reset).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (read register)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i      read enable / address, data appears next cycle
//   rdata_o           registered read data, held while re_i is low
// ---------------------------------------------------------------------------
module seq_bank
  import seq_sram_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/seq_sram_loader.sv
// ---------------------------------------------------------------------------
// seq_sram_loader
//   Host-side counterpart of the SmithWaterman SRAM read interface. Packs a
//   host base stream into a target (T) and a query (Q) word bank, each
//   sequence preceded by a length header word. On host_go_i both lists are
//   terminated with a zero header, start_o pulses, and accelerator reads are
//   served until busy_i falls.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   host_valid_i/host_ready_o/host_base_i/host_last_i/host_sel_T_i
//                   base stream handshake; bank chosen on a sequence's
//                   first base, host_last_i marks its final base
//   host_go_i       finish loading and start the accelerator (IDLE only)
//   start_o         one-cycle start pulse to the accelerator
//   busy_i          accelerator busy
//   select_T_i, addr_i  accelerator read bank / address
//   data_o          registered read data (held outside SERVE)
//   done_o          one-cycle pulse when SERVE ends
//   ovf_o           sticky bank-overflow flag
//   checksum_o      running XOR of written words when built with
//                   SEQ_LOADER_CHECKSUM_EN, otherwise 0
// ---------------------------------------------------------------------------
module seq_sram_loader
  import seq_sram_loader_pkg::*;
#(
  parameter int NUC_W  = DEF_NUC_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [NUC_W-1:0]  host_base_i,
  input  logic              host_last_i,
  input  logic              host_sel_T_i,
  input  logic              host_go_i,
  output logic              start_o,
  input  logic              busy_i,
  input  logic              select_T_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [WORD_W-1:0] data_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic [WORD_W-1:0] checksum_o
);

  localparam int BPW    = bases_per_word(WORD_W, NUC_W);
  localparam int SLOT_W = $clog2(BPW);
  localparam int LEN_W  = len_width(WORD_W, NUC_W, ADDR_W);
  // One extra pointer bit so a pointer can sit just past the last word.
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_LIMIT = PTR_W'(1) << ADDR_W;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BPW - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = '1;

  // Per-bank pointer arrays are indexed by bank: 1 = T, 0 = Q.
  state_e                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [WORD_W-1:0]      pack_q, pack_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [1:0][PTR_W-1:0]  hdr_ptr_q, hdr_ptr_d;
  logic [1:0][PTR_W-1:0]  wptr_q, wptr_d;
  logic                   busy_q;
  logic                   ovf_q, ovf_d;
  logic                   rsel_q;

  logic                   in_idle;
  logic                   acc_bank;
  logic [SLOT_W-1:0]      acc_slot;
  logic [WORD_W-1:0]      acc_pack;
  logic [LEN_W-1:0]       acc_len;
  logic [WORD_W-1:0]      acc_word;
  int                     acc_shamt;

  logic                   ready;
  logic                   start;
  logic                   done;
  logic                   wr_en;
  logic                   wr_bank;
  logic [PTR_W-1:0]       wr_addr;
  logic [WORD_W-1:0]      wr_data;
  logic                   wr_oob;
  logic                   t_we, q_we;
  logic                   t_re, q_re;
  logic [WORD_W-1:0]      t_rdata, q_rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LIMIT) ? p : p + PTR_ONE;
  endfunction

  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] l);
    return (l == LEN_MAX) ? l : l + LEN_W'(1);
  endfunction

  // A sequence's first base arrives in IDLE: it starts from an empty packer
  // and uses the bank sampled right now rather than the latched one.
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    acc_bank  = in_idle ? host_sel_T_i : sel_q;
    acc_slot  = in_idle ? '0 : slot_q;
    acc_pack  = in_idle ? '0 : pack_q;
    acc_len   = in_idle ? '0 : len_q;
    acc_shamt = int'(acc_slot) * NUC_W;
    acc_word  = acc_pack | (WORD_W'(host_base_i) << acc_shamt);
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    slot_d    = slot_q;
    pack_d    = pack_q;
    len_d     = len_q;
    hdr_ptr_d = hdr_ptr_q;
    wptr_d    = wptr_q;
    ready     = 1'b0;
    start     = 1'b0;
    done      = 1'b0;
    wr_en     = 1'b0;
    wr_bank   = sel_q;
    wr_addr   = '0;
    wr_data   = '0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (host_go_i) state_d = ST_TERM_T;
      end
      ST_LOAD: begin
        ready = 1'b1;
      end
      ST_HDR: begin
        wr_en              = 1'b1;
        wr_bank            = sel_q;
        wr_addr            = hdr_ptr_q[sel_q];
        wr_data            = WORD_W'(len_q);
        hdr_ptr_d[sel_q]   = wptr_q[sel_q];
        wptr_d[sel_q]      = ptr_inc(wptr_q[sel_q]);
        len_d              = '0;
        state_d            = ST_IDLE;
      end
      ST_TERM_T: begin
        wr_en   = 1'b1;
        wr_bank = 1'b1;
        wr_addr = hdr_ptr_q[1];
        wr_data = WORD_W'(HDR_TERM);
        state_d = ST_TERM_Q;
      end
      ST_TERM_Q: begin
        wr_en   = 1'b1;
        wr_bank = 1'b0;
        wr_addr = hdr_ptr_q[0];
        wr_data = WORD_W'(HDR_TERM);
        state_d = ST_START;
      end
      ST_START: begin
        start   = 1'b1;
        state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (busy_q && !busy_i) begin
          done      = 1'b1;
          state_d   = ST_IDLE;
          hdr_ptr_d = '0;
          wptr_d    = {PTR_ONE, PTR_ONE};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Base acceptance overrides the go request in the same cycle.
    if (ready && host_valid_i) begin
      sel_d = acc_bank;
      len_d = len_inc(acc_len);
      if (acc_slot == SLOT_LAST || host_last_i) begin
        wr_en            = 1'b1;
        wr_bank          = acc_bank;
        wr_addr          = wptr_q[acc_bank];
        wr_data          = acc_word;
        wptr_d[acc_bank] = ptr_inc(wptr_q[acc_bank]);
        pack_d           = '0;
        slot_d           = '0;
      end else begin
        pack_d = acc_word;
        slot_d = acc_slot + SLOT_W'(1);
      end
      state_d = host_last_i ? ST_HDR : ST_LOAD;
    end
  end

  // Writes past the top of a bank are dropped and flagged.
  always_comb begin
    wr_oob = wr_addr[ADDR_W];
    t_we   = wr_en && !wr_oob && wr_bank;
    q_we   = wr_en && !wr_oob && !wr_bank;
    ovf_d  = ovf_q || (wr_en && wr_oob);
    t_re   = (state_q == ST_SERVE) && select_T_i;
    q_re   = (state_q == ST_SERVE) && !select_T_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      slot_q    <= '0;
      len_q     <= '0;
      hdr_ptr_q <= '0;
      wptr_q    <= {PTR_ONE, PTR_ONE};
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rsel_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      slot_q    <= slot_d;
      len_q     <= len_d;
      hdr_ptr_q <= hdr_ptr_d;
      wptr_q    <= wptr_d;
      busy_q    <= busy_i;
      ovf_q     <= ovf_d;
      if (state_q == ST_SERVE) rsel_q <= select_T_i;
    end
  end

  // Packer contents are only meaningful alongside slot_q, so no reset.
  always_ff @(posedge clk) begin
    pack_q <= pack_d;
  end

  seq_bank #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_bank_t (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (t_we),
    .waddr_i (wr_addr[ADDR_W-1:0]),
    .wdata_i (wr_data),
    .re_i    (t_re),
    .raddr_i (addr_i),
    .rdata_o (t_rdata)
  );

  seq_bank #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_bank_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (q_we),
    .waddr_i (wr_addr[ADDR_W-1:0]),
    .wdata_i (wr_data),
    .re_i    (q_re),
    .raddr_i (addr_i),
    .rdata_o (q_rdata)
  );

`ifdef SEQ_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (done) begin
      csum_d = '0;
    end else if (t_we || q_we) begin
      csum_d = csum_q ^ wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

  // Only the bank last read in SERVE updates, so this mux holds data_o.
  assign data_o       = rsel_q ? t_rdata : q_rdata;
  assign host_ready_o = ready && rst_n;
  assign start_o      = start;
  assign done_o       = done;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_seq_sram_loader.sv
// ---------------------------------------------------------------------------
// tb_seq_sram_loader
//   Randomized bench for seq_sram_loader. A sequence-level model computes
//   each bank's expected words (packed bases, length headers, terminators)
//   and the checksum; bank contents are observed through accelerator reads.
// ---------------------------------------------------------------------------
module tb_seq_sram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_valid_i = 1'b0;
  logic        host_ready_o;
  logic [1:0]  host_base_i = '0;
  logic        host_last_i = 1'b0;
  logic        host_sel_T_i = 1'b0;
  logic        host_go_i = 1'b0;
  logic        start_o;
  logic        busy_i = 1'b0;
  logic        select_T_i = 1'b0;
  logic [7:0]  addr_i = '0;
  logic [15:0] data_o;
  logic        done_o;
  logic        ovf_o;
  logic [15:0] checksum_o;

  always #5 clk = ~clk;

  seq_sram_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_valid_i (host_valid_i),
    .host_ready_o (host_ready_o),
    .host_base_i  (host_base_i),
    .host_last_i  (host_last_i),
    .host_sel_T_i (host_sel_T_i),
    .host_go_i    (host_go_i),
    .start_o      (start_o),
    .busy_i       (busy_i),
    .select_T_i   (select_T_i),
    .addr_i       (addr_i),
    .data_o       (data_o),
    .done_o       (done_o),
    .ovf_o        (ovf_o),
    .checksum_o   (checksum_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Pulse monitors
  int start_cnt = 0;
  int done_cnt  = 0;
  int exp_starts = 0;
  int exp_dones  = 0;
  always @(negedge clk) begin
    if (start_o === 1'b1) start_cnt++;
    if (done_o === 1'b1) done_cnt++;
  end

  // Sequence-level reference model (bank 1 = T, bank 0 = Q)
  logic [15:0] mmem [2][256];
  bit          mval [2][256];
  int          hp [2];
  int          wp [2];
  bit          m_ovf;
  logic [15:0] m_csum;
  logic [15:0] last_exp;
  logic [1:0]  bq [$];

  task automatic model_reset();
    hp[0] = 0; hp[1] = 0;
    wp[0] = 1; wp[1] = 1;
    m_ovf  = 1'b0;
    m_csum = '0;
  endtask

  task automatic mwrite(input int b, input int a, input logic [15:0] d);
    if (a > 255) begin
      m_ovf = 1'b1;
    end else begin
      mmem[b][a] = d;
      mval[b][a] = 1'b1;
      m_csum     = m_csum ^ d;
    end
  endtask

  task automatic model_load(input int b);
    int n;
    int nw;
    logic [15:0] word;
    n  = bq.size();
    nw = (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < 8; k++) begin
        if (w * 8 + k < n) word = word | (16'(bq[w * 8 + k]) << (2 * k));
      end
      mwrite(b, wp[b], word);
      if (wp[b] < 256) wp[b]++;
    end
    // length header; the counter saturates at its 11-bit maximum
    mwrite(b, hp[b], 16'((n > 2047) ? 2047 : n));
    hp[b] = wp[b];
    if (wp[b] < 256) wp[b]++;
  endtask

  task automatic check_csum(input string tag);
`ifdef SEQ_LOADER_CHECKSUM_EN
    check_eq(tag, checksum_o, m_csum);
`else
    check_eq(tag, checksum_o, 16'h0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"},    host_ready_o, 0);
    check_eq({tag, "_start"},    start_o, 0);
    check_eq({tag, "_done"},     done_o, 0);
    check_eq({tag, "_data"},     data_o, 0);
    check_eq({tag, "_ovf"},      ovf_o, 0);
    check_eq({tag, "_checksum"}, checksum_o, 0);
  endtask

  // Entered and left at posedge+1 with the FSM in IDLE.
  task automatic send_seq(input bit bank, input bit with_go);
    bit rdy_drop;
    rdy_drop = 1'b0;
    foreach (bq[i]) begin
      host_valid_i = 1'b1;
      host_base_i  = bq[i];
      host_last_i  = (i == bq.size() - 1);
      host_sel_T_i = (i == 0) ? bank : 1'($urandom);
      host_go_i    = (i == 0) && with_go;
      @(negedge clk);
      if (host_ready_o !== 1'b1) rdy_drop = 1'b1;
      @(posedge clk); #1;
      host_go_i = 1'b0;
    end
    host_valid_i = 1'b0;
    host_last_i  = 1'b0;
    model_load(bank);
    @(negedge clk);
    check_eq("hdr_ready_low", host_ready_o, 0);
    @(negedge clk);
    check_eq("idle_ready_high", host_ready_o, 1);
    check_eq("ready_during_load", rdy_drop, 0);
    check_eq("ovf_flag", ovf_o, m_ovf);
    check_csum("checksum_load");
    @(posedge clk); #1;
  endtask

  task automatic rand_seq(input int len);
    bq.delete();
    for (int i = 0; i < len; i++) bq.push_back(2'($urandom_range(0, 3)));
  endtask

  task automatic read_chk(input string tag, input bit b, input int a, input logic [15:0] exp);
    select_T_i = b;
    addr_i     = 8'(a);
    @(posedge clk); #1;
    check_eq(tag, data_o, exp);
    last_exp = exp;
  endtask

  // Go, check the start timing, read back every modelled word, then
  // optionally drop busy and check the SERVE exit.
  task automatic go_serve(input bit exit_normally, input bit directed);
    host_go_i = 1'b1;
    @(posedge clk); #1;
    host_go_i = 1'b0;
    mwrite(1, hp[1], 16'h0);
    mwrite(0, hp[0], 16'h0);
    exp_starts++;
    @(negedge clk); check_eq("start_early_1", start_o, 0);
    @(negedge clk); check_eq("start_early_2", start_o, 0);
    @(negedge clk); check_eq("start_pulse", start_o, 1);
    @(posedge clk); #1;
    busy_i = 1'b1;
    @(negedge clk); check_eq("start_one_cycle", start_o, 0);
    check_csum("checksum_serve");
    if (directed) begin
      read_chk("dir_T1", 1'b1, 1, 16'h0039);
      read_chk("dir_Q1", 1'b0, 1, 16'hFFFF);
    end
    for (int b = 1; b >= 0; b--) begin
      for (int a = 0; a < 256; a++) begin
        if (mval[b][a]) read_chk(b ? "read_T" : "read_Q", b[0], a, mmem[b][a]);
      end
    end
    if (exit_normally) begin
      busy_i = 1'b0;
      @(negedge clk);
      check_eq("done_pulse", done_o, 1);
      exp_dones++;
      @(posedge clk); #1;
      hp[0] = 0; hp[1] = 0;
      wp[0] = 1; wp[1] = 1;
      m_csum = '0;
      check_eq("done_one_cycle", done_o, 0);
      check_eq("ready_after_done", host_ready_o, 1);
      check_eq("data_hold_exit", data_o, last_exp);
      check_csum("checksum_cleared");
      select_T_i = 1'($urandom);
      addr_i     = 8'($urandom);
      @(posedge clk); @(posedge clk); #1;
      check_eq("data_hold_idle", data_o, last_exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) mval[b][a] = 1'b0;

    // Reset state
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", host_ready_o, 1);
    @(posedge clk); #1;

    // T {1,2,3} then Q nine 3s
    bq = '{2'd1, 2'd2, 2'd3};
    send_seq(1'b1, 1'b0);
    bq.delete();
    for (int i = 0; i < 9; i++) bq.push_back(2'd3);
    send_seq(1'b0, 1'b0);
    go_serve(1'b1, 1'b1);

    // Randomized rounds; the first sequence also raises go with its first base
    for (int r = 0; r < 3; r++) begin
      int nseq;
      nseq = $urandom_range(1, 3);
      for (int s = 0; s < nseq; s++) begin
        rand_seq($urandom_range(2, 20));
        send_seq(1'($urandom), (r == 0) && (s == 0));
      end
      go_serve(1'b1, 1'b0);
    end

    // Overflow: more bases than the T bank holds
    rand_seq(256 * 8 + 8);
    send_seq(1'b1, 1'b0);
    check_eq("ovf_sticky", ovf_o, 1);

    // Reset in the middle of LOAD
    for (int i = 0; i < 3; i++) begin
      host_valid_i = 1'b1;
      host_base_i  = 2'($urandom);
      host_sel_T_i = 1'b1;
      host_last_i  = 1'b0;
      @(posedge clk); #1;
    end
    #3;
    rst_n = 1'b0;
    host_valid_i = 1'b0;
    #1;
    check_all_zero("rst_load");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_eq("ready_after_rst_load", host_ready_o, 1);
    @(posedge clk); #1;

    // Reset in the middle of SERVE
    rand_seq(11);
    send_seq(1'b1, 1'b0);
    go_serve(1'b0, 1'b0);
    #3;
    rst_n  = 1'b0;
    busy_i = 1'b0;
    #1;
    check_all_zero("rst_serve");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_eq("ready_after_rst_serve", host_ready_o, 1);
    @(posedge clk); #1;

    // Next load lands at T[1] again
    rand_seq(13);
    send_seq(1'b1, 1'b0);
    go_serve(1'b1, 1'b0);

    check_eq("start_pulse_count", start_cnt, exp_starts);
    check_eq("done_pulse_count", done_cnt, exp_dones);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
